// File: rtl/params.sv
// Shared definitions for the game sequencer and every stage that decodes
// its state. Keeping the encoding in one place means the overlay, render
// and logic stages all agree on what each game_state value means.
//
// Contents:
//   game_state_t : 2-bit state encoding
//                  START_SCREEN=0, PLAYING=1, PAUSED=2, GAME_OVER=3
package params;

  typedef enum logic [1:0] {
    START_SCREEN = 2'd0,
    PLAYING      = 2'd1,
    PAUSED       = 2'd2,
    GAME_OVER    = 2'd3
  } game_state_t;

endpackage : params

// File: rtl/button_debounce.sv
// Debounces one raw asynchronous push button and turns each accepted press
// into a single-cycle pulse.
//
// A 2-flop synchroniser feeds a stability counter. The debounced level only
// moves after the synchronised level has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles, and any bounce back restarts the count.
// A rising edge of the debounced level gives a one-cycle press pulse.
// Releases produce nothing.
//
// Ports:
//   pixel_clk : clock
//   rst_n     : asynchronous active-low reset
//   btn_raw   : raw button level, active-high, asynchronous to pixel_clk
//   press     : one-cycle registered pulse per accepted press
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic pixel_clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The arm counter must cover the two synchroniser cycles that read 0
  // straight out of reset, otherwise a button held through reset could
  // arm the path before its true level has arrived.
  localparam int ARM_W = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  // A press is only reported once the path is armed, which requires either
  // a quiet (released) stretch after reset or a debounced release. This is
  // what stops a button held across reset from firing when its debounced
  // level first rises.
  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    level_dly_d = level_q;
    cnt_d       = '0;
    arm_cnt_d   = '0;
    armed_d     = armed_q;
    press_d     = armed_q & level_q & ~level_dly_q;

    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        if (level_q) begin
          armed_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!armed_q && !level_q) begin
      if (arm_cnt_q == ARM_LAST) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      arm_cnt_q   <= '0;
      armed_q     <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      arm_cnt_q   <= arm_cnt_d;
      armed_q     <= armed_d;
      press_q     <= press_d;
    end
  end

  assign press = press_q;

endmodule : button_debounce

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer. Debounces the fire and pause buttons, counts
// player lives and produces the 2-bit game_state used by the overlay,
// render and logic stages. Every state change is committed on the fsync
// pulse so no downstream stage sees a change mid-frame.
//
// Ports:
//   pixel_clk     : sole clock
//   rst_n         : asynchronous active-low reset
//   fsync         : one-cycle frame-start pulse, the commit point
//   btn_fire_raw  : raw fire button, active-high
//   btn_pause_raw : raw pause button, active-high
//   player_hit    : one-cycle pulse from collision logic
//   game_state    : 0=START_SCREEN 1=PLAYING 2=PAUSED 3=GAME_OVER
//   lives         : remaining lives
//   game_reset    : one-cycle pulse on the START_SCREEN -> PLAYING commit
module game_state_ctrl
  import params::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int START_LIVES     = 3,
  parameter int LIVES_W         = 2,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               fsync,
  input  logic               btn_fire_raw,
  input  logic               btn_pause_raw,
  input  logic               player_hit,
  output logic [1:0]         game_state,
  output logic [LIVES_W-1:0] lives,
  output logic               game_reset
);

  // A one-frame game-over still needs a 1-bit timer to exist.
  localparam int TIMER_W = (GAMEOVER_FRAMES > 1) ? $clog2(GAMEOVER_FRAMES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GAMEOVER_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);

  logic fire_press;
  logic pause_press;

  game_state_t        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               game_reset_q, game_reset_d;
  logic               fire_pend_q, fire_pend_d;
  logic               pause_pend_q, pause_pend_d;
  logic               hit_pend_q, hit_pend_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_fire_debounce (
    .pixel_clk(pixel_clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_fire_raw),
    .press    (fire_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pause_debounce (
    .pixel_clk(pixel_clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_pause_raw),
    .press    (pause_press)
  );

  // fsync consumes all pending flags whether the current state uses them
  // or not. An event arriving in the fsync cycle itself lands after the
  // clear, so it is held over to the next frame.
  always_comb begin
    fire_pend_d  = fsync ? fire_press  : (fire_pend_q  | fire_press);
    pause_pend_d = fsync ? pause_press : (pause_pend_q | pause_press);
    hit_pend_d   = fsync ? player_hit  : (hit_pend_q   | player_hit);

    state_d      = state_q;
    lives_d      = lives_q;
    timer_d      = timer_q;
    game_reset_d = 1'b0;

    if (fsync) begin
      case (state_q)
        START_SCREEN: begin
          if (fire_pend_q) begin
            state_d      = PLAYING;
            lives_d      = LIVES_INIT;
            game_reset_d = 1'b1;
          end
        end
        PLAYING: begin
          // A hit outranks a pause in the same frame; the pause is dropped.
          if (hit_pend_q) begin
            if (lives_q == LIVES_ONE) begin
              state_d = GAME_OVER;
              lives_d = '0;
              timer_d = '0;
            end else if (lives_q != '0) begin
              lives_d = lives_q - 1'b1;
            end
          end else if (pause_pend_q) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (pause_pend_q) begin
            state_d = PLAYING;
          end
        end
        GAME_OVER: begin
          if (timer_q == TIMER_LAST) begin
            state_d = START_SCREEN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = START_SCREEN;
        end
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= START_SCREEN;
      lives_q      <= '0;
      timer_q      <= '0;
      game_reset_q <= 1'b0;
      fire_pend_q  <= 1'b0;
      pause_pend_q <= 1'b0;
      hit_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      timer_q      <= timer_d;
      game_reset_q <= game_reset_d;
      fire_pend_q  <= fire_pend_d;
      pause_pend_q <= pause_pend_d;
      hit_pend_q   <= hit_pend_d;
    end
  end

  assign game_state = state_q;
  assign lives      = lives_q;
  assign game_reset = game_reset_q;

endmodule : game_state_ctrl

// File: tb/tb_game_state_ctrl.sv
// Directed testbench for game_state_ctrl with a short debounce window
// (4 cycles) and the default 180-frame game-over period. Stimulus is one
// linear sequence of steps; every expected value is written out by hand.
module tb_game_state_ctrl;

  logic       pixel_clk;
  logic       rst_n;
  logic       fsync;
  logic       btn_fire_raw;
  logic       btn_pause_raw;
  logic       player_hit;
  logic [1:0] game_state;
  logic [1:0] lives;
  logic       game_reset;

  int vectors;
  int miscompares;
  int press_count;
  int press_at;

  game_state_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .START_LIVES    (3),
    .LIVES_W        (2),
    .GAMEOVER_FRAMES(180)
  ) dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .fsync        (fsync),
    .btn_fire_raw (btn_fire_raw),
    .btn_pause_raw(btn_pause_raw),
    .player_hit   (player_hit),
    .game_state   (game_state),
    .lives        (lives),
    .game_reset   (game_reset)
  );

  // 10-unit clock period
  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  // Guards against the sequence ever stalling
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and on disagreement counts and reports it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives all inputs for one clock cycle; hit and fsync are pulses and are
  // dropped again afterwards, button levels persist. Returns 1 unit after
  // the sampling edge so outputs are read away from the edge.
  task automatic applyStimulus(input logic fire, input logic pause,
                               input logic hit, input logic fs);
    btn_fire_raw  = fire;
    btn_pause_raw = pause;
    player_hit    = hit;
    fsync         = fs;
    @(posedge pixel_clk);
    #1;
    player_hit = 1'b0;
    fsync      = 1'b0;
  endtask

  task automatic commit_frame();
    applyStimulus(btn_fire_raw, btn_pause_raw, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(btn_fire_raw, btn_pause_raw, 1'b0, 1'b0);
  endtask

  // Clean press-and-release, long enough for the 4-cycle debounce both ways
  task automatic press_button(input logic pause_btn);
    for (int i = 0; i < 12; i++) applyStimulus(!pause_btn, pause_btn, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hit_pulse();
    applyStimulus(btn_fire_raw, btn_pause_raw, 1'b1, 1'b0);
    idle(2);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    fsync         = 1'b0;
    btn_fire_raw  = 1'b0;
    btn_pause_raw = 1'b0;
    player_hit    = 1'b0;

    // Reset state
    idle(3);
    checkOutput("reset_state", 32'(game_state), 32'd0);
    checkOutput("reset_lives", 32'(lives), 32'd0);
    checkOutput("reset_game_reset", 32'(game_reset), 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Bounce: toggle every 2 cycles for 20 cycles, then hold high.
    // One press expected, 2+4+1 = 7 cycles after the final edge.
    press_count = 0;
    press_at    = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(((i / 2) % 2) == 0, 1'b0, 1'b0, 1'b0);
      if (dut.fire_press) press_count++;
    end
    for (int n = 1; n <= 12; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (dut.fire_press) begin
        press_count++;
        press_at = n;
      end
    end
    checkOutput("bounce_press_count", 32'(press_count), 32'd1);
    checkOutput("bounce_press_latency", 32'(press_at), 32'd7);
    press_count = 0;
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (dut.fire_press) press_count++;
    end
    checkOutput("release_no_press", 32'(press_count), 32'd0);

    // Fire pending -> PLAYING with START_LIVES and one game_reset pulse
    commit_frame();
    checkOutput("start_state", 32'(game_state), 32'd1);
    checkOutput("start_lives", 32'(lives), 32'd3);
    checkOutput("start_game_reset_hi", 32'(game_reset), 32'd1);
    idle(1);
    checkOutput("start_game_reset_lo", 32'(game_reset), 32'd0);

    // Hit and pause in the same frame: hit wins, pause dropped
    press_button(1'b1);
    hit_pulse();
    commit_frame();
    checkOutput("hit_pause_lives", 32'(lives), 32'd2);
    checkOutput("hit_pause_state", 32'(game_state), 32'd1);
    idle(3);
    commit_frame();
    checkOutput("pause_dropped_state", 32'(game_state), 32'd1);

    // Hit coincident with fsync is carried to the following frame
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("hit_on_fsync_lives", 32'(lives), 32'd2);
    idle(3);
    commit_frame();
    checkOutput("hit_next_frame_lives", 32'(lives), 32'd1);
    checkOutput("hit_next_frame_state", 32'(game_state), 32'd1);

    // PAUSED: hits ignored, pause resumes
    press_button(1'b1);
    commit_frame();
    checkOutput("paused_state", 32'(game_state), 32'd2);
    hit_pulse();
    commit_frame();
    checkOutput("paused_hit_lives", 32'(lives), 32'd1);
    checkOutput("paused_hit_state", 32'(game_state), 32'd2);
    press_button(1'b1);
    commit_frame();
    checkOutput("resume_state", 32'(game_state), 32'd1);

    // Last life lost -> GAME_OVER
    hit_pulse();
    commit_frame();
    checkOutput("gameover_state", 32'(game_state), 32'd3);
    checkOutput("gameover_lives", 32'(lives), 32'd0);

    // 180 frames in GAME_OVER, back to START_SCREEN on the 180th
    for (int f = 0; f < 179; f++) commit_frame();
    checkOutput("gameover_frame179_state", 32'(game_state), 32'd3);
    commit_frame();
    checkOutput("gameover_return_state", 32'(game_state), 32'd0);
    checkOutput("gameover_return_lives", 32'(lives), 32'd0);

    // New game
    press_button(1'b0);
    commit_frame();
    checkOutput("restart_state", 32'(game_state), 32'd1);
    checkOutput("restart_lives", 32'(lives), 32'd3);
    checkOutput("restart_game_reset", 32'(game_reset), 32'd1);

    // Asynchronous reset mid-game, checked before any clock edge
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_state", 32'(game_state), 32'd0);
    checkOutput("async_reset_lives", 32'(lives), 32'd0);
    checkOutput("async_reset_game_reset", 32'(game_reset), 32'd0);

    // Fire held across reset: no press until released and pressed again
    btn_fire_raw = 1'b1;
    idle(3);
    rst_n = 1'b1;
    press_count = 0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (dut.fire_press) press_count++;
    end
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (dut.fire_press) press_count++;
    end
    checkOutput("held_reset_press_count", 32'(press_count), 32'd0);
    commit_frame();
    checkOutput("held_reset_state", 32'(game_state), 32'd0);
    press_button(1'b0);
    commit_frame();
    checkOutput("repress_state", 32'(game_state), 32'd1);
    checkOutput("repress_lives", 32'(lives), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_game_state_ctrl
